layer_weight_sequencer: RTL and testbench
=========================================

LAYER_WEIGHT_SEQUENCER -- requirements
Module: layer_weight_sequencer

Interface
REQ-001 Parameter SETTLE_CYC, default 2: idle cycles after each weight-select change, before issue.
REQ-002 Parameter TIMEOUT_CYC, default 1024: maximum cycles spent waiting for pe_done in one phase.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to run one full inference pass.
REQ-006 abort  input  1  synchronous cancel of the current pass.
REQ-007 issue_ready  input  1  neuron array accepts the current phase.
REQ-008 pe_done  input  1  one-cycle pulse: the neuron array finished the current phase.
REQ-009 sel  output  2  weight-mux select: 00/01/10 hidden banks 0/1/2, 11 output layer.
REQ-010 issue_valid  output  1  phase ready to issue to the neuron array.
REQ-011 acc_clear  output  1  one-cycle pulse clearing the neuron accumulators at phase entry.
REQ-012 hid_latch  output  1  one-cycle pulse capturing hidden activations before the output phase.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 pass_done  output  1  one-cycle pulse when the output phase completes.
REQ-015 timeout_err  output  1  sticky error flag.

Function
REQ-016 States SHALL be IDLE, SETTLE, ISSUE, WAIT, LATCH and DONE; a 2-bit phase register SHALL hold the value driven on sel.
REQ-017 IDLE: start=1 SHALL set phase=00, go to SETTLE, and pulse acc_clear in that same transition cycle.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, counted by a down-counter, then go to ISSUE.
REQ-019 ISSUE SHALL hold issue_valid=1 until issue_valid&issue_ready, then go to WAIT in the next cycle; issue_valid SHALL NOT drop before acceptance.
REQ-020 WAIT with pe_done=1 and phase<10 SHALL increment phase, pulse acc_clear and go to SETTLE.
REQ-021 WAIT with pe_done=1 and phase=10 SHALL go to LATCH.
REQ-022 LATCH SHALL pulse hid_latch for one cycle, set phase=11, pulse acc_clear and go to SETTLE.
REQ-023 WAIT with pe_done=1 and phase=11 SHALL go to DONE; DONE SHALL pulse pass_done for one cycle and return to IDLE with phase=00.
REQ-024 pe_done SHALL be ignored outside WAIT; start SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-025 A WAIT cycle counter SHALL reset on WAIT entry; reaching TIMEOUT_CYC without pe_done SHALL set timeout_err and go to IDLE with phase=00.
REQ-026 abort SHALL have priority over all other inputs: next state is IDLE, phase=00, and no acc_clear, hid_latch or pass_done pulse is emitted.
REQ-027 If pe_done and the timeout terminal count occur in the same cycle, pe_done SHALL win.
REQ-028 timeout_err SHALL clear only on reset or on an accepted start.
REQ-029 sel SHALL equal the phase register at all times, including IDLE (00), and SHALL change only on state transitions.

Reset
REQ-030 On rst_n=0: state=IDLE, phase=00, all counters 0, and all outputs 0 (sel=00, busy=0, timeout_err=0).
REQ-031 Reset asserted mid-pass SHALL abandon the pass with no pulse outputs; operation resumes from IDLE after rst_n deasserts.

Structure
REQ-032 Package weight_seq_pkg SHALL hold the state enum and the named sel encodings (SEL_HID0, SEL_HID1, SEL_HID2, SEL_OUT).
REQ-033 One sub-module, seq_cycle_counter (loadable down-counter with terminal-count flag), SHALL be used for both the settle and timeout counts.

Verification (SETTLE_CYC=2, TIMEOUT_CYC=16)
REQ-034 Full pass, issue_ready=1, pe_done 5 cycles after each issue -> sel sequence 00,01,10,11; acc_clear pulses 4 times; hid_latch pulses 1 time, before sel=11; pass_done pulses 1 time; busy then falls.
REQ-035 issue_ready held low for 7 cycles in phase 01 -> issue_valid stays high for all 7 cycles with sel=01 stable; no advance occurs.
REQ-036 No pe_done in phase 10 -> timeout_err=1 after 16 WAIT cycles; state IDLE, sel=00; the next start clears timeout_err.
REQ-037 abort in WAIT of phase 11 -> next cycle IDLE, sel=00, busy=0, no pass_done pulse.
REQ-038 start pulsed while busy, plus pe_done pulsed during SETTLE -> both ignored; phase count and pulse counts match REQ-034.
REQ-039 rst_n low during ISSUE of phase 01 -> all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/weight_seq_pkg.sv
// Shared types for the layer weight sequencer: FSM states and weight-mux select codes.
package weight_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ISSUE,
    S_WAIT,
    S_LATCH,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SEL_HID0 = 2'b00,
    SEL_HID1 = 2'b01,
    SEL_HID2 = 2'b10,
    SEL_OUT  = 2'b11
  } sel_e;

endpackage

// File: rtl/seq_cycle_counter.sv
// Loadable down-counter with a terminal-count flag; load wins over decrement, saturates at zero.
module seq_cycle_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/layer_weight_sequencer.sv
// Steps the neuron array through hidden banks 0..2 and the output layer, one weight bank per phase.
module layer_weight_sequencer
  import weight_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       issue_ready,
  input  logic       pe_done,
  output logic [1:0] sel,
  output logic       issue_valid,
  output logic       acc_clear,
  output logic       hid_latch,
  output logic       busy,
  output logic       pass_done,
  output logic       timeout_err
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_LD  = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYC - 1);

  state_e r_state;
  sel_e   r_phase;
  logic   r_issue_valid;
  logic   r_acc_clear;
  logic   r_hid_latch;
  logic   r_pass_done;
  logic   r_timeout_err;

  logic   w_settle_tc;
  logic   w_wait_tc;
  logic   w_in_settle;
  logic   w_in_wait;

  assign w_in_settle = (r_state == S_SETTLE);
  assign w_in_wait   = (r_state == S_WAIT);

  // Both counters reload continuously outside their state, so they start fresh on every entry.
  seq_cycle_counter #(.WIDTH(SW)) u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (!w_in_settle),
    .i_load_val (SETTLE_LD),
    .i_en       (w_in_settle),
    .o_tc       (w_settle_tc)
  );

  seq_cycle_counter #(.WIDTH(TW)) u_wait_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (!w_in_wait),
    .i_load_val (TIMEOUT_LD),
    .i_en       (w_in_wait),
    .o_tc       (w_wait_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_phase       <= SEL_HID0;
      r_issue_valid <= 1'b0;
      r_acc_clear   <= 1'b0;
      r_hid_latch   <= 1'b0;
      r_pass_done   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_acc_clear <= 1'b0;
      r_hid_latch <= 1'b0;
      r_pass_done <= 1'b0;
      if (abort) begin
        r_state       <= S_IDLE;
        r_phase       <= SEL_HID0;
        r_issue_valid <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_state       <= S_SETTLE;
              r_phase       <= SEL_HID0;
              r_acc_clear   <= 1'b1;
              r_timeout_err <= 1'b0;
            end
          end
          S_SETTLE: begin
            if (w_settle_tc) begin
              r_state       <= S_ISSUE;
              r_issue_valid <= 1'b1;
            end
          end
          S_ISSUE: begin
            if (r_issue_valid && issue_ready) begin
              r_state       <= S_WAIT;
              r_issue_valid <= 1'b0;
            end
          end
          S_WAIT: begin
            // pe_done is checked first so it wins against the timeout terminal count.
            if (pe_done) begin
              case (r_phase)
                SEL_HID0: begin
                  r_phase     <= SEL_HID1;
                  r_state     <= S_SETTLE;
                  r_acc_clear <= 1'b1;
                end
                SEL_HID1: begin
                  r_phase     <= SEL_HID2;
                  r_state     <= S_SETTLE;
                  r_acc_clear <= 1'b1;
                end
                SEL_HID2: begin
                  r_state     <= S_LATCH;
                  r_hid_latch <= 1'b1;
                end
                SEL_OUT: begin
                  r_state     <= S_DONE;
                  r_pass_done <= 1'b1;
                end
              endcase
            end else if (w_wait_tc) begin
              r_timeout_err <= 1'b1;
              r_state       <= S_IDLE;
              r_phase       <= SEL_HID0;
            end
          end
          S_LATCH: begin
            r_phase     <= SEL_OUT;
            r_state     <= S_SETTLE;
            r_acc_clear <= 1'b1;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_phase <= SEL_HID0;
          end
          default: begin
            r_state <= S_IDLE;
            r_phase <= SEL_HID0;
          end
        endcase
      end
    end
  end

  assign sel         = r_phase;
  assign issue_valid = r_issue_valid;
  assign acc_clear   = r_acc_clear;
  assign hid_latch   = r_hid_latch;
  assign busy        = (r_state != S_IDLE);
  assign pass_done   = r_pass_done;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_layer_weight_sequencer.sv
// Scoreboard bench for layer_weight_sequencer: expected pulse events are queued at stimulus time.
module tb_layer_weight_sequencer;
  import weight_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       issue_ready;
  logic       pe_done;
  logic [1:0] sel;
  logic       issue_valid;
  logic       acc_clear;
  logic       hid_latch;
  logic       busy;
  logic       pass_done;
  logic       timeout_err;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] evq[$];

  layer_weight_sequencer #(
    .SETTLE_CYC  (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .issue_ready (issue_ready),
    .pe_done     (pe_done),
    .sel         (sel),
    .issue_valid (issue_valid),
    .acc_clear   (acc_clear),
    .hid_latch   (hid_latch),
    .busy        (busy),
    .pass_done   (pass_done),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Event code: kind in upper nibble (1 acc_clear, 2 hid_latch, 3 pass_done), sel in low bits.
  function automatic logic [7:0] ev(input int kind, input logic [1:0] s);
    return {4'(kind), 2'b00, s};
  endfunction

  task automatic mon_ev(input logic [7:0] o);
    logic [7:0] e;
    if (evq.size() == 0) e = 8'h00;
    else e = evq.pop_front();
    chk("event", 32'(o), 32'(e));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (acc_clear) mon_ev(ev(1, sel));
      if (hid_latch) mon_ev(ev(2, sel));
      if (pass_done) mon_ev(ev(3, sel));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_evs(input int n);
    logic [7:0] full [6];
    full[0] = ev(1, SEL_HID0);
    full[1] = ev(1, SEL_HID1);
    full[2] = ev(1, SEL_HID2);
    full[3] = ev(2, SEL_HID2);
    full[4] = ev(1, SEL_OUT);
    full[5] = ev(3, SEL_OUT);
    for (int i = 0; i < n; i++) evq.push_back(full[i]);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("err_clr", 32'(timeout_err), 32'd0);
    chk("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic wait_accept(input logic [1:0] exp_sel, input int hold);
    int n;
    if (hold > 0) issue_ready = 1'b0;
    n = 0;
    while (!issue_valid && n < 20) begin
      tick;
      n++;
    end
    chk("issue_seen", 32'(issue_valid), 32'd1);
    chk("issue_sel", 32'(sel), 32'(exp_sel));
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(issue_valid), 32'd1);
      chk("hold_sel", 32'(sel), 32'(exp_sel));
      tick;
    end
    issue_ready = 1'b1;
    tick;
    chk("valid_drop", 32'(issue_valid), 32'd0);
  endtask

  task automatic do_phase(input logic [1:0] exp_sel, input int delay, input int hold, input bit noise);
    if (noise) begin
      start   = 1'b1;
      pe_done = 1'b1;
      tick;
      start   = 1'b0;
      pe_done = 1'b0;
    end
    wait_accept(exp_sel, hold);
    repeat (delay - 1) tick;
    pe_done = 1'b1;
    tick;
    pe_done = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick;
      n++;
    end
  endtask

  task automatic run_pass(input bit noise, input int d_out, input int hold1);
    push_evs(6);
    do_start;
    do_phase(SEL_HID0, 5, 0, noise);
    do_phase(SEL_HID1, 5, hold1, noise);
    do_phase(SEL_HID2, 5, 0, noise);
    do_phase(SEL_OUT, d_out, 0, 1'b0);
    wait_idle;
    chk("pass_busy", 32'(busy), 32'd0);
    chk("pass_sel", 32'(sel), 32'd0);
    chk("pass_err", 32'(timeout_err), 32'd0);
    tick;
    tick;
    chk("no_restart", 32'(busy), 32'd0);
    chk("evq_empty", 32'(evq.size()), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    issue_ready = 1'b1;
    pe_done     = 1'b0;
    #3;
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;

    // Plain pass, then stall in phase 01, then spurious start/pe_done while busy.
    run_pass(1'b0, 5, 0);
    run_pass(1'b0, 5, 7);
    run_pass(1'b1, 5, 0);

    // Timeout in phase 10.
    push_evs(3);
    do_start;
    do_phase(SEL_HID0, 5, 0, 1'b0);
    do_phase(SEL_HID1, 5, 0, 1'b0);
    wait_accept(SEL_HID2, 0);
    repeat (15) tick;
    chk("to_edge_err", 32'(timeout_err), 32'd0);
    chk("to_edge_busy", 32'(busy), 32'd1);
    tick;
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_sel", 32'(sel), 32'd0);
    tick;
    tick;
    chk("to_sticky", 32'(timeout_err), 32'd1);
    chk("to_evq", 32'(evq.size()), 32'd0);

    // Next start clears the flag; pe_done on the terminal-count cycle must win.
    run_pass(1'b0, 16, 0);

    // Abort in WAIT of the output phase.
    push_evs(5);
    do_start;
    do_phase(SEL_HID0, 5, 0, 1'b0);
    do_phase(SEL_HID1, 5, 0, 1'b0);
    do_phase(SEL_HID2, 5, 0, 1'b0);
    wait_accept(SEL_OUT, 0);
    tick;
    tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_valid", 32'(issue_valid), 32'd0);
    repeat (4) tick;
    chk("abort_evq", 32'(evq.size()), 32'd0);

    // Asynchronous reset during ISSUE of phase 01.
    push_evs(2);
    do_start;
    do_phase(SEL_HID0, 5, 0, 1'b0);
    issue_ready = 1'b0;
    begin
      int n;
      n = 0;
      while (!issue_valid && n < 20) begin
        tick;
        n++;
      end
    end
    chk("pre_rst_valid", 32'(issue_valid), 32'd1);
    chk("pre_rst_sel", 32'(sel), 32'(SEL_HID1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_valid", 32'(issue_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_clr", 32'(acc_clear), 32'd0);
    chk("arst_latch", 32'(hid_latch), 32'd0);
    chk("arst_done", 32'(pass_done), 32'd0);
    chk("arst_err", 32'(timeout_err), 32'd0);
    tick;
    rst_n       = 1'b1;
    issue_ready = 1'b1;
    tick;
    chk("arst_evq", 32'(evq.size()), 32'd0);
    run_pass(1'b0, 5, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
